oam_scan: RTL

- Mode-2 OAM search stage of the PPU.
- On each line start it walks all 40 OAM entries and tests each object's Y against the current line (8 or 16 px tall).
- It pushes up to 10 hits, in OAM order, into the head of the obj_entry shift chain using obj_load / o_in.
- It reports the hit count to the downstream fetcher/mixer.

---
 rtl/ppu_pkg.sv | 65 ++++++
 rtl/oam_scan.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants, plus the object/line hit test that both the
// OAM scan and the pixel mixer use.
package ppu_pkg;

  localparam int unsigned OAM_ENTRIES   = 40;
  localparam int unsigned MAX_LINE_OBJS = 10;
  localparam int unsigned OBJ_Y_OFS     = 16;

  typedef struct packed {
    logic       prio;
    logic       yflip;
    logic       xflip;
    logic       dmg_pal;
    logic       bank;
    logic [2:0] cgb_pal;
  } obj_attr_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] idx;
    obj_attr_t  attr;
  } obj_t;

  typedef struct packed {
    logic lcd_en;
    logic win_map;
    logic win_en;
    logic tile_sel;
    logic bg_map;
    logic obj_size;
    logic obj_en;
    logic bg_en;
  } lcdc_t;

  typedef struct packed {
    logic       unused;
    logic       lyc_int;
    logic       oam_int;
    logic       vblank_int;
    logic       hblank_int;
    logic       lyc_eq;
    logic [1:0] mode;
  } stat_t;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_FETCH,
    SCAN_CHECK,
    SCAN_DONE
  } scan_state_e;

  // Evaluated in 9 bits so y + height never wraps.
  function automatic logic obj_on_line(input logic [7:0] y, input logic [7:0] ly,
                                       input logic tall);
    logic [8:0] t;
    logic [8:0] top;
    logic [8:0] h;
    t   = {1'b0, ly} + 9'(OBJ_Y_OFS);
    top = {1'b0, y};
    h   = tall ? 9'd16 : 9'd8;
    return (t >= top) && (t < top + h);
  endfunction

endpackage

// File: rtl/oam_scan.sv
// Mode-2 OAM search: walks every OAM entry once per line and shifts up to
// MAX_OBJS objects that cover the current line into the obj_entry chain.
module oam_scan #(
  parameter int unsigned OAM_ENTRIES = 40,
  parameter int unsigned MAX_OBJS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic        obj_size,
  output logic [5:0]  oam_idx,
  output logic        oam_rd,
  input  logic [31:0] oam_data,
  output logic        obj_clr,
  output logic        obj_load,
  output logic [31:0] obj_out,
  output logic [3:0]  obj_count,
  output logic        busy,
  output logic        done
);
  import ppu_pkg::*;

  scan_state_e state_q, state_d;
  logic [7:0]  ly_q, ly_d;
  logic        tall_q, tall_d;
  logic [5:0]  oam_idx_q, oam_idx_d;
  logic        oam_rd_q, oam_rd_d;
  logic        obj_clr_q, obj_clr_d;
  logic        obj_load_q, obj_load_d;
  logic [31:0] obj_out_q, obj_out_d;
  logic [3:0]  obj_count_q, obj_count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hit;

  // y is the most significant byte of obj_t.
  assign hit = obj_on_line(oam_data[31:24], ly_q, tall_q);

  always_comb begin
    state_d     = state_q;
    ly_d        = ly_q;
    tall_d      = tall_q;
    oam_idx_d   = oam_idx_q;
    oam_rd_d    = 1'b0;
    obj_clr_d   = 1'b0;
    obj_load_d  = 1'b0;
    obj_out_d   = obj_out_q;
    obj_count_d = obj_count_q;
    done_d      = 1'b0;

    // start pre-empts every state, including a CHECK with a pending hit.
    if (start) begin
      ly_d        = ly;
      tall_d      = obj_size;
      oam_idx_d   = '0;
      obj_count_d = '0;
      obj_clr_d   = 1'b1;
      oam_rd_d    = 1'b1;
      state_d     = SCAN_FETCH;
    end else begin
      case (state_q)
        SCAN_FETCH: state_d = SCAN_CHECK;
        SCAN_CHECK: begin
          if (hit && (obj_count_q < 4'(MAX_OBJS))) begin
            obj_load_d  = 1'b1;
            obj_out_d   = oam_data;
            obj_count_d = obj_count_q + 4'd1;
          end
          if (oam_idx_q == 6'(OAM_ENTRIES - 1)) begin
            done_d  = 1'b1;
            state_d = SCAN_DONE;
          end else begin
            oam_idx_d = oam_idx_q + 6'd1;
            oam_rd_d  = 1'b1;
            state_d   = SCAN_FETCH;
          end
        end
        SCAN_DONE: state_d = SCAN_IDLE;
        default:   state_d = SCAN_IDLE;
      endcase
    end

    busy_d = (state_d == SCAN_FETCH) || (state_d == SCAN_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN_IDLE;
      ly_q        <= '0;
      tall_q      <= 1'b0;
      oam_idx_q   <= '0;
      oam_rd_q    <= 1'b0;
      obj_clr_q   <= 1'b0;
      obj_load_q  <= 1'b0;
      obj_out_q   <= '0;
      obj_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ly_q        <= ly_d;
      tall_q      <= tall_d;
      oam_idx_q   <= oam_idx_d;
      oam_rd_q    <= oam_rd_d;
      obj_clr_q   <= obj_clr_d;
      obj_load_q  <= obj_load_d;
      obj_out_q   <= obj_out_d;
      obj_count_q <= obj_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign oam_idx   = oam_idx_q;
  assign oam_rd    = oam_rd_q;
  assign obj_clr   = obj_clr_q;
  assign obj_load  = obj_load_q;
  assign obj_out   = obj_out_q;
  assign obj_count = obj_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
